// File: rtl/stdp_pkg.sv
// Shared helpers for the STDP pair: saturating add, clamp and trace decay.
package stdp_pkg;

  // Unsigned add that saturates at 2^width-1 instead of wrapping.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned width);
    longint unsigned max_v;
    longint unsigned sum;
    max_v = (64'd1 << width) - 64'd1;
    sum   = 64'(a) + 64'(b);
    return (sum > max_v) ? 32'(max_v) : 32'(sum);
  endfunction

  // Clamp a signed value into [0, hi].
  function automatic int unsigned clamp_u(input int signed v, input int unsigned hi);
    if (v < 0) begin
      return 0;
    end else if (unsigned'(v) > hi) begin
      return hi;
    end
    return unsigned'(v);
  endfunction

  // Geometric decay; once the shifted step reaches zero, fall back to -1 so the
  // trace always reaches exactly zero.
  function automatic int unsigned trace_decay(input int unsigned t, input int unsigned shift);
    int unsigned step;
    step = t >> shift;
    if (step != 0) begin
      return t - step;
    end else if (t != 0) begin
      return t - 1;
    end
    return 0;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with saturating membrane and refractory period.
module lif_neuron #(
  parameter int unsigned SW         = 8,
  parameter int unsigned THRESH     = 200,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [SW-1:0] current,
  output logic          spike,
  output logic [SW-1:0] state
);
  import stdp_pkg::*;

  // Counter is kept at least one bit wide so REFRAC=0 still elaborates.
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RW-1:0] REFRAC_V = RW'(REFRAC);

  logic [SW-1:0] state_q, state_d, leaked;
  logic [RW-1:0] refrac_q, refrac_d;
  logic          spike_q, spike_d;

  // Next state: refractory blanking, then fire check, then leak-and-integrate.
  always_comb begin
    state_d  = state_q;
    refrac_d = refrac_q;
    spike_d  = 1'b0;
    leaked   = state_q - (state_q >> LEAK_SHIFT);
    if (refrac_q != '0) begin
      state_d  = '0;
      refrac_d = refrac_q - RW'(1);
    end else if (32'(state_q) >= THRESH) begin
      spike_d  = 1'b1;
      state_d  = '0;
      refrac_d = REFRAC_V;
    end else begin
      state_d = SW'(sat_add(32'(leaked), 32'(current), SW));
    end
  end

  // State registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      refrac_q <= '0;
      spike_q  <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      refrac_q <= refrac_d;
      spike_q  <= spike_d;
    end
  end

  assign spike = spike_q;
  assign state = state_q;

endmodule

// File: rtl/stdp_pair.sv
// Pre LIF neuron drives a post LIF neuron through one synapse whose weight is
// adapted by trace-based STDP (LTP on post spikes, LTD on pre spikes).
module stdp_pair #(
  parameter int unsigned SW          = 8,
  parameter int unsigned THRESH      = 200,
  parameter int unsigned LEAK_SHIFT  = 1,
  parameter int unsigned REFRAC      = 2,
  parameter int unsigned WW          = 8,
  parameter int unsigned W_INIT      = 1,
  parameter int unsigned TW          = 8,
  parameter int unsigned DECAY_SHIFT = 2,
  parameter int unsigned LTP_SHIFT   = 4,
  parameter int unsigned LTD_SHIFT   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [SW-1:0] pre_current,
  input  logic [SW-1:0] post_bias,
  input  logic          learn_en,
  input  logic          w_load,
  input  logic [WW-1:0] w_in,
  output logic          pre_spike,
  output logic          post_spike,
  output logic [WW-1:0] weight,
  output logic [SW-1:0] pre_state,
  output logic [SW-1:0] post_state
);
  import stdp_pkg::*;

  localparam logic [TW-1:0] TRACE_MAX = '1;
  localparam int unsigned   W_MAX     = (1 << WW) - 1;

  logic [SW-1:0]        post_current;
  logic [TW-1:0]        pre_trace_q, pre_trace_d, post_trace_q, post_trace_d;
  logic [TW-1:0]        ltp_delta, ltd_delta;
  logic [WW-1:0]        weight_q, weight_d;
  logic signed [WW+1:0] w_sum;

  lif_neuron #(
    .SW        (SW),
    .THRESH    (THRESH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRAC    (REFRAC)
  ) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .current(pre_current),
    .spike  (pre_spike),
    .state  (pre_state)
  );

  // Post input: bias plus the weight whenever the registered pre spike is high.
  always_comb begin
    post_current = SW'(sat_add(32'(post_bias), pre_spike ? 32'(weight_q) : 32'd0, SW));
  end

  lif_neuron #(
    .SW        (SW),
    .THRESH    (THRESH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRAC    (REFRAC)
  ) u_post (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .current(post_current),
    .spike  (post_spike),
    .state  (post_state)
  );

  // Traces jump to max on the registered spike, otherwise decay toward zero.
  always_comb begin
    pre_trace_d  = pre_spike  ? TRACE_MAX : TW'(trace_decay(32'(pre_trace_q), DECAY_SHIFT));
    post_trace_d = post_spike ? TRACE_MAX : TW'(trace_decay(32'(post_trace_q), DECAY_SHIFT));
  end

  // Weight: load wins over learning; STDP sum uses pre-edge traces, clamped.
  always_comb begin
    ltp_delta = post_spike ? (pre_trace_q >> LTP_SHIFT) : '0;
    ltd_delta = pre_spike ? (post_trace_q >> LTD_SHIFT) : '0;
    w_sum     = $signed({2'b00, weight_q}) + $signed((WW+2)'(ltp_delta))
              - $signed((WW+2)'(ltd_delta));
    weight_d  = weight_q;
    if (w_load) begin
      weight_d = w_in;
    end else if (learn_en) begin
      weight_d = WW'(clamp_u(int'(w_sum), W_MAX));
    end
  end

  // Trace and weight registers; hold while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_trace_q  <= '0;
      post_trace_q <= '0;
      weight_q     <= WW'(W_INIT);
    end else if (ena) begin
      pre_trace_q  <= pre_trace_d;
      post_trace_q <= post_trace_d;
      weight_q     <= weight_d;
    end
  end

  assign weight = weight_q;

endmodule
